// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss stopwatch controller.
//   sw_state_t : controller state encoding
//   bcd_t      : one BCD digit
//   SEC_T_MAX  : highest seconds-tens digit
//   DIG_MAX    : highest value of a decimal digit
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_T_MAX = 4'd5;
  localparam bcd_t DIG_MAX   = 4'd9;

  localparam int unsigned DISP_W = 16;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of the stopwatch count.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : count enable for the whole chain
//   clr        : synchronous clear to 0 (wins over inc)
//   carry_in   : lower digits are rolling over this cycle
//   q          : registered digit value
//   q_nxt_c    : value q takes on the next edge
//   carry_out  : this digit rolls over when the chain steps
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = DIG_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  input  logic carry_in,
  output bcd_t q,
  output bcd_t q_nxt_c,
  output logic carry_out
);

  assign carry_out = carry_in && (q == MAX);

  // Next digit value
  always_comb begin
    q_nxt_c = q;
    if (clr) begin
      q_nxt_c = 4'd0;
    end else if (inc && carry_in) begin
      q_nxt_c = (q == MAX) ? 4'd0 : q + 4'd1;
    end
  end

  // Digit register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 4'd0;
    end else begin
      q <= q_nxt_c;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear controller for the mm:ss stopwatch.
// Optional lap feature: define STOPWATCH_LAP_EN to build the LAP state and
// the lap register; without it lap_active is tied 0 and lap_pulse only
// clears a paused count.
//   clk, reset  : clock, asynchronous active-high reset
//   tick        : one-second count enable
//   start_pulse : start/stop button pulse
//   lap_pulse   : lap/clear button pulse
//   run         : state is RUN or LAP
//   lap_active  : state is LAP (display frozen)
//   disp_bcd    : {min_t,min_u,sec_t,sec_u}, lap value in LAP else live count
//   overflow    : one-cycle pulse when a tick passes MIN_MAX:59
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned MIN_MAX = 59,
  parameter bit          WRAP    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              start_pulse,
  input  logic              lap_pulse,
  output logic              run,
  output logic              lap_active,
  output logic [DISP_W-1:0] disp_bcd,
  output logic              overflow
);

  localparam bcd_t MIN_T_MAX = 4'(MIN_MAX / 10);
  localparam bcd_t MIN_U_MAX = 4'(MIN_MAX % 10);

  sw_state_t state_q, state_nxt;

  logic              cnt_en_c;
  logic              at_max_c;
  logic              ovf_c;
  logic              inc_c;
  logic              clr_c;
  logic              fsm_clr_c;
  logic              lap_cap_c;
  logic [4:0]        carry;
  bcd_t              dig_q   [4];
  bcd_t              dig_nxt [4];
  logic [DISP_W-1:0] count_q;
  logic [DISP_W-1:0] count_nxt;
  logic [DISP_W-1:0] disp_nxt;

  assign count_q   = {dig_q[3], dig_q[2], dig_q[1], dig_q[0]};
  assign count_nxt = {dig_nxt[3], dig_nxt[2], dig_nxt[1], dig_nxt[0]};

  // Count datapath: sec_u, sec_t, min_u, min_t with rippled carries
  assign carry[0] = 1'b1;

  bcd_digit_cnt #(.MAX(DIG_MAX)) u_sec_u (
    .clk(clk), .reset(reset), .inc(inc_c), .clr(clr_c), .carry_in(carry[0]),
    .q(dig_q[0]), .q_nxt_c(dig_nxt[0]), .carry_out(carry[1]));

  bcd_digit_cnt #(.MAX(SEC_T_MAX)) u_sec_t (
    .clk(clk), .reset(reset), .inc(inc_c), .clr(clr_c), .carry_in(carry[1]),
    .q(dig_q[1]), .q_nxt_c(dig_nxt[1]), .carry_out(carry[2]));

  bcd_digit_cnt #(.MAX(DIG_MAX)) u_min_u (
    .clk(clk), .reset(reset), .inc(inc_c), .clr(clr_c), .carry_in(carry[2]),
    .q(dig_q[2]), .q_nxt_c(dig_nxt[2]), .carry_out(carry[3]));

  bcd_digit_cnt #(.MAX(DIG_MAX)) u_min_t (
    .clk(clk), .reset(reset), .inc(inc_c), .clr(clr_c), .carry_in(carry[3]),
    .q(dig_q[3]), .q_nxt_c(dig_nxt[3]), .carry_out(carry[4]));

  // Minute-limit compare; carry[2] means seconds read 59. 99:59 is only
  // reachable when MIN_MAX is 99, so the natural rollover joins the same path.
  assign cnt_en_c = (state_q == RUN) || (state_q == LAP);
  assign at_max_c = (carry[2] && (dig_q[3] == MIN_T_MAX) && (dig_q[2] == MIN_U_MAX))
                    || carry[4];
  assign ovf_c    = cnt_en_c && tick && at_max_c;
  // Without wrap the count holds at the limit instead of stepping
  assign inc_c    = cnt_en_c && tick && !(at_max_c && !WRAP);
  assign clr_c    = fsm_clr_c || (ovf_c && WRAP);

  // Next-state logic; start has priority over lap, limit-hold forces PAUSE
  always_comb begin
    state_nxt = state_q;
    fsm_clr_c = 1'b0;
    lap_cap_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_pulse) state_nxt = RUN;
      end
      RUN: begin
        if (start_pulse) begin
          state_nxt = PAUSE;
        end
`ifdef STOPWATCH_LAP_EN
        else if (lap_pulse) begin
          state_nxt = LAP;
          lap_cap_c = 1'b1;
        end
`endif
      end
      PAUSE: begin
        if (start_pulse) begin
          state_nxt = RUN;
        end else if (lap_pulse) begin
          state_nxt = IDLE;
          fsm_clr_c = 1'b1;
        end
      end
`ifdef STOPWATCH_LAP_EN
      LAP: begin
        if (start_pulse) begin
          state_nxt = PAUSE;
        end else if (lap_pulse) begin
          state_nxt = RUN;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
    if (ovf_c && !WRAP) begin
      state_nxt = PAUSE;
      lap_cap_c = 1'b0;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [DISP_W-1:0] lap_q;
  logic [DISP_W-1:0] lap_nxt;

  assign lap_nxt  = lap_cap_c ? count_q : lap_q;
  assign disp_nxt = (state_nxt == LAP) ? lap_nxt : count_nxt;

  // Lap capture and frozen-display flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_q      <= '0;
      lap_active <= 1'b0;
    end else begin
      lap_q      <= lap_nxt;
      lap_active <= (state_nxt == LAP);
    end
  end
`else
  assign disp_nxt   = count_nxt;
  assign lap_active = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      run      <= 1'b0;
      disp_bcd <= '0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      run      <= (state_nxt == RUN) || (state_nxt == LAP);
      disp_bcd <= disp_nxt;
      overflow <= ovf_c;
    end
  end

endmodule
